multi_digit_lock: RTL and testbench
===================================

# multi_digit_lock

Parametrised multi-digit combination lock FSM, successor to the single-digit lock top. It accepts an N-digit code entered one digit per `enter` pulse. It counts failed attempts and enforces a timed alarm lockout after `MAX_TRIES` failures. It supports atomic reprogramming of the stored code while open, with optional auto-relock. It sits after the `enter`/`change` input conditioners and drives the 2-bit status consumed by the seven-segment decoder.

## Interface
Parameters:
- `DIGIT_W`, 4, width of one code digit
- `N_DIGITS`, 4, digits per code (≥1)
- `MAX_TRIES`, 3, consecutive failed codes that trigger alarm (≥1)
- `LOCKOUT_CYCLES`, 1000, alarm duration in clock cycles (≥1)
- `RELOCK_CYCLES`, 0, cycles in OPEN before automatic relock; 0 disables auto-relock
- `RESET_CODE`, 0, `N_DIGITS*DIGIT_W`-bit code loaded at reset; digit 0 is in the LSBs

Ports:
- `clock` in 1: single clock; all state changes on the rising edge
- `reset` in 1: synchronous, active-high
- `digit` in `DIGIT_W`: current digit value, sampled only on an accepted `enter`
- `enter` in 1: single-cycle pulse from the conditioner, one digit per pulse
- `change` in 1: single-cycle pulse from the conditioner
- `status` out 2: 00 locked, 01 alarm, 10 new, 11 open
- `open` out 1: high in OPEN
- `alarm` out 1: high in ALARM
- `new_mode` out 1: high in NEW
- `digit_idx` out `clog2(N_DIGITS+1)`: digits entered so far in the current entry
- `tries_left` out `clog2(MAX_TRIES+1)`: remaining attempts before alarm

## Operation
- States: LOCKED, OPEN, NEW, ALARM.
- Reset: state LOCKED; stored code = `RESET_CODE`; `digit_idx` 0; mismatch flag 0; `tries_left` = `MAX_TRIES`; timers 0; status 00; `open`, `alarm` and `new_mode` all 0.
- `enter` and `change` high in the same cycle: `change` wins and `enter` is dropped.
- LOCKED behaviour:
  - `enter`: compare `digit` against stored digit[`digit_idx`]; OR any mismatch into the sticky flag; increment `digit_idx`.
  - On the N-th digit, all matched: go to OPEN; `tries_left` reloads to `MAX_TRIES`; `digit_idx` 0; flag cleared.
  - On the N-th digit, any mismatch: decrement `tries_left`. If it reaches 0, go to ALARM and load the lockout timer with `LOCKOUT_CYCLES`. Otherwise stay in LOCKED. In both cases `digit_idx` 0 and flag cleared.
  - `change`: abort the partial entry (`digit_idx` 0, flag cleared). No try is consumed.
  - The mismatch position is never exposed; only the final verdict is visible.
- OPEN behaviour:
  - `enter`: go to LOCKED (manual relock).
  - `change`: go to NEW with `digit_idx` 0.
  - If `RELOCK_CYCLES` > 0, the timer loads on entry to OPEN and counts down; at 0 with no pulse pending, go to LOCKED.
  - A `change` in the expiry cycle wins and goes to NEW.
- NEW behaviour:
  - `enter`: write `digit` into shadow buffer slot `digit_idx`; increment.
  - On the N-th digit, commit the shadow buffer to the stored code in one cycle, then go to LOCKED.
  - `change`: abort; the shadow buffer is discarded and the stored code is unchanged; go to OPEN (relock timer reloads).
- ALARM behaviour:
  - `enter` and `change` are ignored; `digit_idx` is held at 0.
  - The timer decrements each cycle. When it reaches 0, go to LOCKED with `tries_left` = `MAX_TRIES`.
- `reset` asserted in any state, including mid-entry, mid-programming or during lockout, returns to the reset values. This includes reverting the stored code to `RESET_CODE`.
- Widths: counters saturate and never wrap. `digit_idx` ranges 0..`N_DIGITS`-1 between events.

## Timing
- All outputs are registered. A pulse sampled at edge k is reflected on the outputs after edge k, i.e. 1-cycle latency.
- Verdict latency: the state change is visible in the cycle after the N-th `enter`.
- The ALARM→LOCKED transition occurs exactly `LOCKOUT_CYCLES` cycles after the cycle in which `alarm` first reads 1.
- Auto-relock: `open` reads 1 for exactly `RELOCK_CYCLES` cycles when no pulses arrive.
- The code commit and the NEW→LOCKED transition happen on the same edge. The new code is valid for the next `enter`.
- Back-to-back `enter` pulses on consecutive cycles are accepted without loss.

## Test plan
- Reset, default params, digits 0,0,0,0 on four `enter` pulses → status 11, `open`=1 the cycle after the 4th pulse, `tries_left`=3.
- Code 0,0,0,0 active, enter 1,0,0,0 three times → after the 3rd entry `alarm`=1, status 01. It holds exactly 1000 cycles while ignoring `enter`/`change`, then status 00 with `tries_left`=3.
- From OPEN: `change`, then digits 9,3,7,2 → status 00. Enter 9,3,7,2 → open. Enter 0,0,0,0 → reject, `tries_left`=2.
- In NEW after 2 digits, `change` → OPEN, and the old code still opens the lock.
- `enter` and `change` together in LOCKED after 2 digits → `digit_idx`=0 and `tries_left` unchanged. With `RELOCK_CYCLES`=5, OPEN lasts exactly 5 cycles.
- `reset` pulsed mid-NEW and mid-ALARM → all outputs return to reset values and `RESET_CODE` opens the lock.

Source files
------------

// File: rtl/multi_digit_lock.sv
// Multi-digit combination lock: N-digit entry, try counter with timed alarm
// lockout, atomic code reprogramming while open, optional auto-relock.
module multi_digit_lock #(
   parameter int DIGIT_W        = 4,
   parameter int N_DIGITS       = 4,
   parameter int MAX_TRIES      = 3,
   parameter int LOCKOUT_CYCLES = 1000,
   parameter int RELOCK_CYCLES  = 0,
   parameter logic [N_DIGITS*DIGIT_W-1:0] RESET_CODE = '0,
   localparam int IDX_W = $clog2(N_DIGITS+1),
   localparam int TRY_W = $clog2(MAX_TRIES+1)
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [DIGIT_W-1:0] digit,
   input  logic               enter,
   input  logic               change,
   output logic [1:0]         status,
   output logic               open,
   output logic               alarm,
   output logic               new_mode,
   output logic [IDX_W-1:0]   digit_idx,
   output logic [TRY_W-1:0]   tries_left
);

   localparam int TMR_MAX = (LOCKOUT_CYCLES > RELOCK_CYCLES) ?
                            LOCKOUT_CYCLES : RELOCK_CYCLES;
   localparam int TMR_W   = $clog2(TMR_MAX+1);
   localparam int CODE_W  = N_DIGITS*DIGIT_W;

   // Encoding doubles as the status output
   typedef enum logic [1:0] {
      S_LOCKED = 2'b00,
      S_ALARM  = 2'b01,
      S_NEW    = 2'b10,
      S_OPEN   = 2'b11
   } state_e;

   state_e              state_q, state_d;
   logic [CODE_W-1:0]   code_q, code_d;
   logic [CODE_W-1:0]   shadow_q, shadow_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic                flag_q, flag_d;
   logic [TRY_W-1:0]    tries_q, tries_d;
   logic [TMR_W-1:0]    tmr_q, tmr_d;

   logic [DIGIT_W-1:0]  cur_digit;
   logic                last;
   logic                miss;
   logic [IDX_W-1:0]    idx_inc;
   logic [TRY_W-1:0]    tries_dec;
   logic [TMR_W-1:0]    tmr_dec;

   always_comb begin
      cur_digit = '0;
      for (int i = 0; i < N_DIGITS; i++) begin
         if (idx_q == IDX_W'(i)) cur_digit = code_q[i*DIGIT_W +: DIGIT_W];
      end
   end

   assign last      = (idx_q == IDX_W'(N_DIGITS-1));
   assign miss      = (digit != cur_digit);
   assign idx_inc   = last ? idx_q : idx_q + 1'b1;
   assign tries_dec = (tries_q == '0) ? '0 : tries_q - 1'b1;
   assign tmr_dec   = (tmr_q == '0) ? '0 : tmr_q - 1'b1;

   always_comb begin
      state_d  = state_q;
      code_d   = code_q;
      shadow_d = shadow_q;
      idx_d    = idx_q;
      flag_d   = flag_q;
      tries_d  = tries_q;
      tmr_d    = tmr_q;
      unique case (state_q)
         S_LOCKED: begin
            if (change) begin
               idx_d  = '0;
               flag_d = 1'b0;
            end else if (enter) begin
               if (last) begin
                  idx_d  = '0;
                  flag_d = 1'b0;
                  if (!(flag_q || miss)) begin
                     state_d = S_OPEN;
                     tries_d = TRY_W'(MAX_TRIES);
                     tmr_d   = TMR_W'(RELOCK_CYCLES);
                  end else begin
                     tries_d = tries_dec;
                     if (tries_dec == '0) begin
                        state_d = S_ALARM;
                        tmr_d   = TMR_W'(LOCKOUT_CYCLES);
                     end
                  end
               end else begin
                  idx_d  = idx_inc;
                  flag_d = flag_q | miss;
               end
            end
         end
         S_OPEN: begin
            if (change) begin
               state_d = S_NEW;
               idx_d   = '0;
            end else if (enter) begin
               state_d = S_LOCKED;
            end else if (RELOCK_CYCLES > 0) begin
               if (tmr_q <= TMR_W'(1)) begin
                  state_d = S_LOCKED;
                  tmr_d   = '0;
               end else begin
                  tmr_d = tmr_dec;
               end
            end
         end
         S_NEW: begin
            if (change) begin
               state_d = S_OPEN;
               idx_d   = '0;
               tmr_d   = TMR_W'(RELOCK_CYCLES);
            end else if (enter) begin
               for (int i = 0; i < N_DIGITS; i++) begin
                  if (idx_q == IDX_W'(i)) shadow_d[i*DIGIT_W +: DIGIT_W] = digit;
               end
               if (last) begin
                  code_d  = shadow_d;
                  state_d = S_LOCKED;
                  idx_d   = '0;
               end else begin
                  idx_d = idx_inc;
               end
            end
         end
         S_ALARM: begin
            idx_d = '0;
            if (tmr_q <= TMR_W'(1)) begin
               state_d = S_LOCKED;
               tries_d = TRY_W'(MAX_TRIES);
               tmr_d   = '0;
            end else begin
               tmr_d = tmr_dec;
            end
         end
         default: state_d = S_LOCKED;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= S_LOCKED;
         code_q   <= RESET_CODE;
         shadow_q <= '0;
         idx_q    <= '0;
         flag_q   <= 1'b0;
         tries_q  <= TRY_W'(MAX_TRIES);
         tmr_q    <= '0;
      end else begin
         state_q  <= state_d;
         code_q   <= code_d;
         shadow_q <= shadow_d;
         idx_q    <= idx_d;
         flag_q   <= flag_d;
         tries_q  <= tries_d;
         tmr_q    <= tmr_d;
      end
   end

   assign status     = state_q;
   assign open       = (state_q == S_OPEN);
   assign alarm      = (state_q == S_ALARM);
   assign new_mode   = (state_q == S_NEW);
   assign digit_idx  = idx_q;
   assign tries_left = tries_q;

endmodule

// File: tb/tb_multi_digit_lock.sv
// Directed bench for multi_digit_lock: per-cycle vector table plus
// hand-written alarm, reset and auto-relock sequences.
module tb_multi_digit_lock;

   localparam logic [1:0] L = 2'b00;
   localparam logic [1:0] A = 2'b01;
   localparam logic [1:0] N = 2'b10;
   localparam logic [1:0] O = 2'b11;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] digit;
   logic       enter;
   logic       change;

   logic [1:0] status;
   logic       open, alarm, new_mode;
   logic [2:0] digit_idx;
   logic [1:0] tries_left;

   logic [1:0] r_status;
   logic       r_open, r_alarm, r_new_mode;
   logic [2:0] r_digit_idx;
   logic [1:0] r_tries_left;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   multi_digit_lock u_dut (
      .clock(clk), .reset(reset), .digit(digit),
      .enter(enter), .change(change),
      .status(status), .open(open), .alarm(alarm),
      .new_mode(new_mode), .digit_idx(digit_idx),
      .tries_left(tries_left)
   );

   multi_digit_lock #(.RELOCK_CYCLES(5)) u_rl (
      .clock(clk), .reset(reset), .digit(digit),
      .enter(enter), .change(change),
      .status(r_status), .open(r_open), .alarm(r_alarm),
      .new_mode(r_new_mode), .digit_idx(r_digit_idx),
      .tries_left(r_tries_left)
   );

   typedef struct {
      logic       en;
      logic       ch;
      logic [3:0] d;
      logic [1:0] st;
      logic [2:0] idx;
      logic [1:0] tr;
   } vec_t;

   vec_t tv[$];

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", nm, got, exp);
      end
   endtask

   function automatic logic [9:0] pack_exp(input logic [1:0] st,
                                           input logic [2:0] idx,
                                           input logic [1:0] tr);
      return {st, st == O, st == A, st == N, idx, tr};
   endfunction

   function automatic logic [9:0] pack_got();
      return {status, open, alarm, new_mode, digit_idx, tries_left};
   endfunction

   task automatic apply(input logic en, input logic ch, input logic [3:0] d);
      @(negedge clk);
      enter  = en;
      change = ch;
      digit  = d;
      @(posedge clk);
      #1;
   endtask

   task automatic enter_code(input logic [15:0] c);
      for (int k = 0; k < 4; k++) apply(1'b1, 1'b0, c[k*4 +: 4]);
   endtask

   task automatic do_reset(input bit chk_it, input string nm);
      @(negedge clk);
      reset  = 1'b1;
      enter  = 1'b0;
      change = 1'b0;
      digit  = '0;
      @(posedge clk);
      #1;
      if (chk_it) chk(nm, pack_got(), pack_exp(L, 3'd0, 2'd3));
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic add(input logic en, input logic ch, input logic [3:0] d,
                      input logic [1:0] st, input logic [2:0] idx,
                      input logic [1:0] tr);
      tv.push_back('{en, ch, d, st, idx, tr});
   endtask

   initial begin
      int cnt;
      int bad;
      reset  = 1'b1;
      enter  = 1'b0;
      change = 1'b0;
      digit  = '0;

      // open with 0000, relock, abort, first-digit and last-digit misses
      add(1,0,0, L,1,3); add(1,0,0, L,2,3); add(1,0,0, L,3,3);
      add(1,0,0, O,0,3); add(1,0,5, L,0,3);
      add(1,0,1, L,1,3); add(1,0,0, L,2,3); add(1,1,0, L,0,3);
      add(1,0,1, L,1,3); add(1,0,0, L,2,3); add(1,0,0, L,3,3);
      add(1,0,0, L,0,2); add(0,0,0, L,0,2); add(0,1,0, L,0,2);
      add(1,0,0, L,1,2); add(1,0,0, L,2,2); add(1,0,0, L,3,2);
      add(1,0,0, O,0,3);
      // program 9,3,7,2
      add(0,1,0, N,0,3); add(1,0,9, N,1,3); add(1,0,3, N,2,3);
      add(1,0,7, N,3,3); add(1,0,2, L,0,3);
      // old code rejected, new code opens
      add(1,0,0, L,1,3); add(1,0,0, L,2,3); add(1,0,0, L,3,3);
      add(1,0,0, L,0,2);
      add(1,0,9, L,1,2); add(1,0,3, L,2,2); add(1,0,7, L,3,2);
      add(1,0,2, O,0,3);
      // aborted programming keeps the code
      add(0,1,0, N,0,3); add(1,0,1, N,1,3); add(1,0,1, N,2,3);
      add(0,1,0, O,0,3); add(1,0,0, L,0,3);
      add(1,0,9, L,1,3); add(1,0,3, L,2,3); add(1,0,7, L,3,3);
      add(1,0,2, O,0,3); add(1,0,0, L,0,3);
      add(1,0,9, L,1,3); add(1,0,3, L,2,3); add(1,0,7, L,3,3);
      add(1,0,3, L,0,2); add(0,0,0, L,0,2);

      do_reset(1'b1, "reset_init");
      foreach (tv[i]) begin
         apply(tv[i].en, tv[i].ch, tv[i].d);
         chk($sformatf("vec%0d", i), pack_got(),
             pack_exp(tv[i].st, tv[i].idx, tv[i].tr));
      end

      // alarm lockout length and input blanking
      do_reset(1'b0, "");
      repeat (3) enter_code(16'h0001);
      chk("alarm_on", pack_got(), pack_exp(A, 3'd0, 2'd0));
      cnt = 1;
      bad = 0;
      for (int c = 1; c < 3000; c++) begin
         apply(c % 7 == 0, c % 11 == 0, 4'd1);
         if (digit_idx !== 3'd0) bad++;
         if (alarm === 1'b1) cnt++;
         else break;
      end
      chk("alarm_len", cnt, 1000);
      chk("alarm_idx", bad, 0);
      chk("alarm_exit", pack_got(), pack_exp(L, 3'd0, 2'd3));
      enter_code(16'h0000);
      chk("post_alarm_open", pack_got(), pack_exp(O, 3'd0, 2'd3));

      // reset mid-programming reverts a committed code
      do_reset(1'b0, "");
      enter_code(16'h0000);
      apply(0, 1, 0);
      enter_code(16'h2739);
      enter_code(16'h2739);
      chk("new_code_open", pack_got(), pack_exp(O, 3'd0, 2'd3));
      apply(0, 1, 0);
      apply(1, 0, 1);
      apply(1, 0, 1);
      chk("mid_new", pack_got(), pack_exp(N, 3'd2, 2'd3));
      do_reset(1'b1, "reset_mid_new");
      enter_code(16'h2739);
      chk("stale_code_rej", pack_got(), pack_exp(L, 3'd0, 2'd2));
      enter_code(16'h0000);
      chk("reset_code_open", pack_got(), pack_exp(O, 3'd0, 2'd3));

      // reset during lockout
      do_reset(1'b0, "");
      repeat (3) enter_code(16'h0001);
      repeat (10) apply(0, 0, 0);
      chk("mid_alarm", pack_got(), pack_exp(A, 3'd0, 2'd0));
      do_reset(1'b1, "reset_mid_alarm");
      enter_code(16'h0000);
      chk("alarm_reset_open", pack_got(), pack_exp(O, 3'd0, 2'd3));

      // auto-relock length, then change in the expiry cycle
      do_reset(1'b0, "");
      enter_code(16'h0000);
      cnt = 0;
      while (r_open === 1'b1 && cnt < 20) begin
         cnt++;
         apply(0, 0, 0);
      end
      chk("relock_len", cnt, 5);
      chk("relock_state", {r_status, r_tries_left}, {L, 2'd3});
      enter_code(16'h0000);
      repeat (4) apply(0, 0, 0);
      chk("relock_pre", {r_status, r_open}, {O, 1'b1});
      apply(0, 1, 0);
      chk("relock_change", {r_status, r_new_mode, r_digit_idx},
          {N, 1'b1, 3'd0});

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
